img_scaler_core: RTL

//  Parametrised successor of the fixed 160x120 zoom path: maps a screen coordinate request to a scaled image pixel.

---
 rtl/scaler_pkg.sv | 30 +++
 rtl/scaler_window.sv | 51 +++++
 rtl/img_scaler_core.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared defaults, FSM encoding and width helpers for the image scaler.
package scaler_pkg;

    localparam int IMG_W_DEF   = 160;
    localparam int IMG_H_DEF   = 120;
    localparam int SCR_W_DEF   = 640;
    localparam int SCR_H_DEF   = 480;
    localparam int PIX_W_DEF   = 8;
    localparam int K_MAX_DEF   = 3;
    localparam int MEM_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OFF,
        ST_DONE
    } state_t;

    // Largest displayed extent along one axis needs this many bits of relative coordinate.
    function automatic int rel_width(input int img, input int k_max);
        return $clog2(img << k_max);
    endfunction

    // Room for 4^k_max full-scale pixels.
    function automatic int acc_width(input int pix_w, input int k_max);
        return pix_w + 2 * k_max;
    endfunction

endpackage

// File: rtl/scaler_window.sv
// Places the scaled image on the screen: centers a small display, center-crops an oversize one,
// and converts a screen coordinate into a coordinate relative to the displayed image.
module scaler_window import scaler_pkg::*; #(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF,
    parameter int K_MAX = K_MAX_DEF
) (
    input  logic                                zoom_in,
    input  logic [$clog2(K_MAX+1)-1:0]          k,
    input  logic [$clog2(SCR_W)-1:0]            req_x,
    input  logic [$clog2(SCR_H)-1:0]            req_y,
    output logic                                in_win,
    output logic [rel_width(IMG_W, K_MAX)-1:0]  x_rel,
    output logic [rel_width(IMG_H, K_MAX)-1:0]  y_rel
);

    localparam int RXW = rel_width(IMG_W, K_MAX);
    localparam int RYW = rel_width(IMG_H, K_MAX);

    logic [31:0] dw, dh, ox, oy;
    logic        crop_x, crop_y, in_x, in_y;

    always_comb begin
        dw     = zoom_in ? (32'(IMG_W) << k) : (32'(IMG_W) >> k);
        crop_x = dw > 32'(SCR_W);
        ox     = crop_x ? ((dw - 32'(SCR_W)) >> 1) : ((32'(SCR_W) - dw) >> 1);
        if (crop_x) begin
            in_x  = 1'b1;
            x_rel = RXW'(32'(req_x) + ox);
        end else begin
            in_x  = (32'(req_x) >= ox) && (32'(req_x) < ox + dw);
            x_rel = RXW'(32'(req_x) - ox);
        end

        dh     = zoom_in ? (32'(IMG_H) << k) : (32'(IMG_H) >> k);
        crop_y = dh > 32'(SCR_H);
        oy     = crop_y ? ((dh - 32'(SCR_H)) >> 1) : ((32'(SCR_H) - dh) >> 1);
        if (crop_y) begin
            in_y  = 1'b1;
            y_rel = RYW'(32'(req_y) + oy);
        end else begin
            in_y  = (32'(req_y) >= oy) && (32'(req_y) < oy + dh);
            y_rel = RYW'(32'(req_y) - oy);
        end

        in_win = in_x && in_y;
    end

endmodule

// File: rtl/img_scaler_core.sv
// Maps a screen coordinate request to a scaled image pixel: window mapping, frame-memory read
// sequencing and 2^k x 2^k block averaging, one request in flight.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high; a source
// holds valid and its payload stable until that edge; ready never depends on the same side's valid.
module img_scaler_core import scaler_pkg::*; #(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int SCR_W   = SCR_W_DEF,
    parameter int SCR_H   = SCR_H_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int K_MAX   = K_MAX_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_zoom_in,
    input  logic                        cfg_avg,
    input  logic [$clog2(K_MAX+1)-1:0]  cfg_k,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(SCR_W)-1:0]    req_x,
    input  logic [$clog2(SCR_H)-1:0]    req_y,
    output logic                        mem_rd_en,
    output logic [$clog2(IMG_W)-1:0]    mem_x,
    output logic [$clog2(IMG_H)-1:0]    mem_y,
    input  logic [PIX_W-1:0]            mem_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PIX_W-1:0]            out_pixel,
    output logic                        out_on_image,
    output state_t                      dbg_state
);

    localparam int KW    = $clog2(K_MAX + 1);
    localparam int XI    = $clog2(IMG_W);
    localparam int YI    = $clog2(IMG_H);
    localparam int RXW   = rel_width(IMG_W, K_MAX);
    localparam int RYW   = rel_width(IMG_H, K_MAX);
    localparam int ACC_W = acc_width(PIX_W, K_MAX);
    localparam int CNT_W = 2 * K_MAX + 1;
    localparam int SW    = K_MAX;

    state_t state, state_nx;

    logic           in_win, accept, ret_valid;
    logic [RXW-1:0] x_rel;
    logic [RYW-1:0] y_rel;

    logic [KW-1:0]      k_r;
    logic               avg_r;
    logic [KW:0]        shift_amt;
    logic [CNT_W-1:0]   n_last, rd_cnt, ret_cnt;
    logic [SW-1:0]      dx, side_last;
    logic [XI-1:0]      base_x;
    logic [MEM_LAT-1:0] pipe;
    logic [ACC_W-1:0]   acc, sum;

    scaler_window #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .SCR_W (SCR_W),
        .SCR_H (SCR_H),
        .K_MAX (K_MAX)
    ) u_window (
        .zoom_in (cfg_zoom_in),
        .k       (cfg_k),
        .req_x   (req_x),
        .req_y   (req_y),
        .in_win  (in_win),
        .x_rel   (x_rel),
        .y_rel   (y_rel)
    );

    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign mem_rd_en = (state == ST_ISSUE);
    assign out_valid = (state == ST_OFF) || (state == ST_DONE);
    assign ret_valid = pipe[MEM_LAT-1];
    assign dbg_state = state;

    // Non-averaging requests (and k=0) collapse to one read with no final shift.
    assign shift_amt = avg_r ? {k_r, 1'b0} : '0;
    assign n_last    = CNT_W'((32'd1 << shift_amt) - 32'd1);
    assign side_last = SW'((32'd1 << k_r) - 32'd1);
    assign sum       = acc + ACC_W'(mem_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // OFF presents its result straight away; it only falls into DONE when downstream stalls.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nx = in_win ? ST_ISSUE : ST_OFF;
            ST_ISSUE: if (rd_cnt == n_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (ret_valid && (ret_cnt == n_last)) state_nx = ST_DONE;
            ST_OFF:   state_nx = out_ready ? ST_IDLE : ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe         <= '0;
            k_r          <= '0;
            avg_r        <= 1'b0;
            base_x       <= '0;
            mem_x        <= '0;
            mem_y        <= '0;
            dx           <= '0;
            rd_cnt       <= '0;
            ret_cnt      <= '0;
            acc          <= '0;
            out_pixel    <= '0;
            out_on_image <= 1'b0;
        end else begin
            pipe[0] <= mem_rd_en;
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];

            if (accept) begin
                k_r          <= cfg_k;
                avg_r        <= !cfg_zoom_in && cfg_avg;
                base_x       <= XI'(cfg_zoom_in ? (32'(x_rel) >> cfg_k) : (32'(x_rel) << cfg_k));
                mem_x        <= XI'(cfg_zoom_in ? (32'(x_rel) >> cfg_k) : (32'(x_rel) << cfg_k));
                mem_y        <= YI'(cfg_zoom_in ? (32'(y_rel) >> cfg_k) : (32'(y_rel) << cfg_k));
                dx           <= '0;
                rd_cnt       <= '0;
                ret_cnt      <= '0;
                acc          <= '0;
                out_pixel    <= '0;
                out_on_image <= 1'b0;
            end

            // Raster walk of the block, dx fastest; the address stays on the last read once done.
            if (mem_rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt != n_last) begin
                    if (dx == side_last) begin
                        dx    <= '0;
                        mem_x <= base_x;
                        mem_y <= mem_y + 1'b1;
                    end else begin
                        dx    <= dx + 1'b1;
                        mem_x <= mem_x + 1'b1;
                    end
                end
            end

            if (ret_valid) begin
                acc     <= sum;
                ret_cnt <= ret_cnt + 1'b1;
                if (ret_cnt == n_last) begin
                    out_pixel    <= PIX_W'(sum >> shift_amt);
                    out_on_image <= 1'b1;
                end
            end
        end
    end

endmodule
